boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter INST_MEM_WIDTH, default 14, instruction-memory word-address width.
REQ-002 Parameter ACK_BYTE, default 8'hAA, byte sent on successful load.
REQ-003 Parameter ERR_BYTE, default 8'hEE, byte sent on header error.
REQ-004 CLK  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx_valid  input  1  one-cycle strobe per byte from the UART receiver.
REQ-007 rx_data  input  8  received byte; valid only when rx_valid=1.
REQ-008 tx_valid  output  1  byte offered to the UART transmitter.
REQ-009 tx_data  output  8  byte offered; held stable while tx_valid=1.
REQ-010 tx_ready  input  1  transmitter accepts tx_data when tx_valid=1 and tx_ready=1 in the same cycle.
REQ-011 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-012 imem_addr  output  INST_MEM_WIDTH  word address of the write.
REQ-013 imem_wdata  output  32  word written.
REQ-014 cpu_run  output  1  releases the CPU core; low holds the core in reset.
REQ-015 error  output  1  sticky load-failure flag.
REQ-016 state_out  output  3  current state encoding, driven to the LEDs.

Function
REQ-017 The load protocol SHALL be a 4-byte big-endian word count N, followed by N 4-byte big-endian instruction words.
REQ-018 The block SHALL implement states HDR, LOAD, WRITE, ACK, RUN and ERR.
REQ-019 In HDR, each rx_valid byte SHALL shift into the assembler, MSB first; after the 4th byte N SHALL be latched.
REQ-020 On header completion, N=0 SHALL go to ACK, N>2**INST_MEM_WIDTH SHALL go to ERR, and any other N SHALL go to LOAD.
REQ-021 In LOAD, the 4th byte of a word SHALL move the block to WRITE in the next cycle.
REQ-022 WRITE SHALL last exactly one cycle, with imem_we=1, imem_addr=word index and imem_wdata=assembled word.
REQ-023 After WRITE, the word index SHALL increment; the next state SHALL be ACK if the index equals N, else LOAD.
REQ-024 Write latency SHALL be exactly 1 cycle from the rx_valid of the 4th byte to imem_we=1.
REQ-025 An rx_valid arriving during WRITE SHALL be captured as byte 0 of the next word and not dropped.
REQ-026 Byte-in-word counter SHALL be 2 bits and wrap 3->0; word index SHALL be INST_MEM_WIDTH+1 bits so N=2**INST_MEM_WIDTH is reachable.
REQ-027 In ACK, tx_valid=1 and tx_data=ACK_BYTE SHALL hold until the handshake; the following cycle SHALL be RUN.
REQ-028 In RUN, cpu_run=1 SHALL hold until reset; rx_valid SHALL be ignored and no further writes occur.
REQ-029 On entry to ERR, ERR_BYTE SHALL be sent once via the same handshake; error=1 SHALL stay set and cpu_run=0 until reset.
REQ-030 rx_valid in ACK, RUN or ERR SHALL be ignored.
REQ-031 imem_we SHALL be 0 in every state except WRITE.
REQ-032 tx_valid SHALL never deassert before the handshake completes.

Reset
REQ-033 Asserting reset SHALL immediately set state=HDR, cpu_run=0, imem_we=0, tx_valid=0, error=0, imem_addr=0, imem_wdata=0, tx_data=0, and clear all counters and the assembler.
REQ-034 Reset mid-load SHALL discard the partial word; the next byte after release SHALL be treated as header byte 0.
REQ-035 Reset during ACK SHALL abandon the pending byte without completing the handshake.

Structure
REQ-036 Package boot_pkg SHALL hold the state enum (3-bit) and default ACK/ERR byte constants.
REQ-037 Sub-module byte_assembler SHALL hold the 4-byte shift register, 2-bit counter and word-complete pulse, reused for the header and for data words.

Verification
REQ-038 Header 00 00 00 02, then 12 34 56 78 and 9A BC DE F0 -> writes (0, 0x12345678), then (1, 0x9ABCDEF0); then tx 0xAA; then cpu_run=1.
REQ-039 Header 00 00 00 00 -> no imem_we; 0xAA sent; cpu_run=1.
REQ-040 Header 00 00 40 01 with INST_MEM_WIDTH=14 -> 0xEE sent; error=1; cpu_run stays 0; following bytes cause no writes.
REQ-041 tx_ready held 0 for 10 cycles in ACK -> tx_valid=1 with tx_data=0xAA held stable; RUN entered the cycle after tx_ready=1.
REQ-042 Reset asserted after 2 bytes of word 1, then a fresh header of count 1 plus word 0xDEADBEEF -> single write (0, 0xDEADBEEF).
REQ-043 Back-to-back rx_valid on consecutive cycles, including during WRITE -> all words written correctly with no dropped byte.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader.
// State encoding is what the LEDs display.
package boot_pkg;

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_ACK   = 3'd3,
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    localparam logic [7:0] DEF_ACK_BYTE = 8'hAA;
    localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;

    function automatic logic [31:0] be_shift(
        input logic [31:0] acc,
        input logic [7:0]  b
    );
        return {acc[23:0], b};
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Big-endian 4-byte shift register with a 2-bit byte counter.
// Used for both the header word count and instruction words.
module byte_assembler
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic [31:0] word_next,
    output logic        done
);

    logic [31:0] sr_q;
    logic [31:0] sr_d;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            sr_d  = be_shift(sr_q, in_byte);
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // done is combinational so the owner can act on the 4th byte's cycle
    assign done      = in_valid && (cnt_q == 2'd3);
    assign word      = sr_q;
    assign word_next = be_shift(sr_q, in_byte);

endmodule

// File: rtl/boot_loader.sv
// UART boot loader: header word count, N big-endian words into imem,
// then ACK (or ERR) byte and CPU release.
module boot_loader
    import boot_pkg::*;
#(
    parameter int         INST_MEM_WIDTH = 14,
    parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE,
    parameter logic [7:0] ERR_BYTE       = DEF_ERR_BYTE
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    output logic                      imem_we,
    output logic [INST_MEM_WIDTH-1:0] imem_addr,
    output logic [31:0]               imem_wdata,
    output logic                      cpu_run,
    output logic                      error,
    output logic [2:0]                state_out
);

    localparam int IW = INST_MEM_WIDTH + 1;
    localparam logic [32:0] N_MAX = 33'd1 << INST_MEM_WIDTH;

    state_e        state_q;
    state_e        state_d;
    logic [IW-1:0] n_q;
    logic [IW-1:0] n_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic [IW-1:0] idx_inc;
    logic          err_sent_q;
    logic          err_sent_d;

    logic          asm_valid;
    logic [31:0]   asm_word;
    logic [31:0]   asm_next;
    logic          asm_done;

    // WRITE still accepts bytes so a back-to-back stream is not dropped
    assign asm_valid = rx_valid && (state_q == S_HDR ||
                                    state_q == S_LOAD ||
                                    state_q == S_WRITE);

    byte_assembler u_asm (
        .clk       (CLK),
        .rst       (reset),
        .in_valid  (asm_valid),
        .in_byte   (rx_data),
        .word      (asm_word),
        .word_next (asm_next),
        .done      (asm_done)
    );

    assign idx_inc = idx_q + IW'(1);

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        err_sent_d = err_sent_q;
        unique case (state_q)
            S_HDR: begin
                if (asm_done) begin
                    if (asm_next == 32'd0) begin
                        state_d = S_ACK;
                    end else if ({1'b0, asm_next} > N_MAX) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = asm_next[IW-1:0];
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (asm_done) state_d = S_WRITE;
            end
            S_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == n_q) ? S_ACK : S_LOAD;
            end
            S_ACK: begin
                if (tx_ready) state_d = S_RUN;
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            S_ERR: begin
                if (!err_sent_q && tx_ready) err_sent_d = 1'b1;
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= S_HDR;
            n_q        <= '0;
            idx_q      <= '0;
            err_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            err_sent_q <= err_sent_d;
        end
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        if (state_q == S_ACK) begin
            tx_valid = 1'b1;
            tx_data  = ACK_BYTE;
        end else if (state_q == S_ERR && !err_sent_q) begin
            tx_valid = 1'b1;
            tx_data  = ERR_BYTE;
        end
    end

    // Shift register still holds the whole word during WRITE
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = idx_q[INST_MEM_WIDTH-1:0];
    assign imem_wdata = asm_word;
    assign cpu_run    = (state_q == S_RUN);
    assign error      = (state_q == S_ERR);
    assign state_out  = state_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader against a byte-stream reference model.
// Expected writes and tx bytes are derived from the byte list alone.
module tb_boot_loader;
    import boot_pkg::*;

    localparam int IMW = 14;

    logic        CLK;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        imem_we;
    logic [IMW-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        error;
    logic [2:0]  state_out;

    boot_loader #(.INST_MEM_WIDTH(IMW)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .error      (error),
        .state_out  (state_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0]  stim[$];
    int          exp_a[$];
    logic [31:0] exp_d[$];
    int          lat_q[$];
    logic [7:0]  obs_tx[$];
    logic [7:0]  exp_tx;
    logic        pv;
    logic [7:0]  pd;
    logic        phs;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Observer: writes against the model queue, tx capture, tx stability
    always @(negedge CLK) begin
        if (!reset) begin
            if (imem_we) begin
                if (exp_a.size() == 0) begin
                    chk("spurious_we", 1, 0);
                end else begin
                    chk("waddr", 32'(imem_addr), 32'(exp_a.pop_front()));
                    chk("wdata", imem_wdata, exp_d.pop_front());
                    if (lat_q.size() > 0)
                        chk("wlat", cyc, lat_q.pop_front() + 1);
                end
            end
            if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
            if (pv && !phs) begin
                chk("tx_hold_v", 32'(tx_valid), 1);
                chk("tx_hold_d", 32'(tx_data), 32'(pd));
            end
            pv  = tx_valid;
            pd  = tx_data;
            phs = tx_valid && tx_ready;
        end else begin
            pv  = 1'b0;
            phs = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        rx_valid = 1'b0;
        #1;
        chk("rst_state", 32'(state_out), 32'(S_HDR));
        chk("rst_run", 32'(cpu_run), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_txv", 32'(tx_valid), 0);
        chk("rst_err", 32'(error), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_txd", 32'(tx_data), 0);
        exp_a.delete();
        exp_d.delete();
        lat_q.delete();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    // Reference: N from the first 4 bytes, then N big-endian words
    task automatic run_case(input int gap_max, input int ready_delay);
        logic [31:0] n;
        int nw;
        int t;
        nw = 0;
        obs_tx.delete();
        n = {stim[0], stim[1], stim[2], stim[3]};
        if (n == 0) begin
            exp_tx = 8'hAA;
        end else if (n > (32'd1 << IMW)) begin
            exp_tx = 8'hEE;
        end else begin
            exp_tx = 8'hAA;
            nw = int'(n);
            for (int i = 0; i < nw; i++) begin
                exp_a.push_back(i);
                exp_d.push_back({stim[4+4*i], stim[5+4*i],
                                 stim[6+4*i], stim[7+4*i]});
            end
        end
        tx_ready = (ready_delay == 0);
        for (int k = 0; k < stim.size(); k++) begin
            if (k >= 4 && (k - 4) % 4 == 3 && (k - 4) / 4 < nw)
                lat_q.push_back(cyc);
            send_byte(stim[k]);
            repeat ($urandom_range(0, gap_max)) tick();
        end
        t = 0;
        while (!tx_valid && obs_tx.size() == 0 && t < 200) begin
            tick();
            t++;
        end
        chk("tx_seen", 32'(t < 200), 1);
        if (ready_delay > 0) begin
            repeat (ready_delay) begin
                chk("wait_txv", 32'(tx_valid), 1);
                chk("wait_txd", 32'(tx_data), 32'(exp_tx));
                tick();
            end
            tx_ready = 1'b1;
            tick();
            chk("post_hs_state", 32'(state_out),
                32'(exp_tx == 8'hAA ? S_RUN : S_ERR));
        end
        repeat (4) tick();
        for (int k = 0; k < 3; k++) send_byte(8'($urandom));
        repeat (3) tick();
        chk("writes_left", exp_a.size(), 0);
        chk("tx_count", obs_tx.size(), 1);
        chk("tx_byte", 32'(obs_tx.size() > 0 ? obs_tx[0] : 8'h00),
            32'(exp_tx));
        chk("cpu_run", 32'(cpu_run), 32'(exp_tx == 8'hAA));
        chk("error", 32'(error), 32'(exp_tx == 8'hEE));
        chk("end_txv", 32'(tx_valid), 0);
        chk("end_state", 32'(state_out),
            32'(exp_tx == 8'hAA ? S_RUN : S_ERR));
    endtask

    initial begin
        int n;
        int t;
        logic [31:0] w;
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        tx_ready = 1'b0;
        pv = 1'b0;
        pd = 8'h00;
        phs = 1'b0;
        repeat (2) tick();
        do_reset();

        stim = '{8'h00, 8'h00, 8'h00, 8'h02,
                 8'h12, 8'h34, 8'h56, 8'h78,
                 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_case(1, 10);

        do_reset();
        stim = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_case(0, 0);

        do_reset();
        stim = '{8'h00, 8'h00, 8'h40, 8'h01,
                 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h07, 8'h08};
        run_case(0, 2);

        do_reset();
        stim = '{8'h00, 8'h00, 8'h40, 8'h00};
        foreach (stim[k]) send_byte(stim[k]);
        chk("nmax_load", 32'(state_out), 32'(S_LOAD));
        chk("nmax_err", 32'(error), 0);

        do_reset();
        exp_a.push_back(0);
        exp_d.push_back(32'h11223344);
        stim = '{8'h00, 8'h00, 8'h00, 8'h02,
                 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        foreach (stim[k]) send_byte(stim[k]);
        repeat (2) tick();
        chk("pre_rst_writes", exp_a.size(), 0);
        do_reset();
        stim = '{8'h00, 8'h00, 8'h00, 8'h01,
                 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_case(0, 0);

        do_reset();
        obs_tx.delete();
        tx_ready = 1'b0;
        stim = '{8'h00, 8'h00, 8'h00, 8'h00};
        foreach (stim[k]) send_byte(stim[k]);
        t = 0;
        while (!tx_valid && t < 50) begin
            tick();
            t++;
        end
        chk("ack_pending", 32'(tx_valid), 1);
        repeat (3) tick();
        do_reset();
        tx_ready = 1'b1;
        repeat (3) tick();
        chk("ack_abandon_tx", obs_tx.size(), 0);
        chk("ack_abandon_st", 32'(state_out), 32'(S_HDR));

        for (int r = 0; r < 8; r++) begin
            do_reset();
            n = $urandom_range(1, 6);
            stim.delete();
            stim.push_back(8'h00);
            stim.push_back(8'h00);
            stim.push_back(8'h00);
            stim.push_back(8'(n));
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                stim.push_back(w[31:24]);
                stim.push_back(w[23:16]);
                stim.push_back(w[15:8]);
                stim.push_back(w[7:0]);
            end
            repeat ($urandom_range(0, 2)) stim.push_back(8'($urandom));
            run_case(r < 3 ? 0 : int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
